// File: rtl/ex_stage.sv
// Execute stage: single-cycle integer ALU plus a multi-cycle unsigned shift-add multiplier.
// Optional build macro EX_OVERFLOW_EN adds a registered signed-overflow flag for ADD/SUB.
module ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [3:0]       alu_op,
    input  logic             alu_src,
    input  logic [WIDTH-1:0] data_a_in,
    input  logic [WIDTH-1:0] data_b_in,
    input  logic [WIDTH-1:0] sign_extend_in,
    output logic [WIDTH-1:0] result_out,
    output logic [WIDTH-1:0] hi_out,
    output logic             zero_out,
    output logic             valid_out,
    output logic             stall_out
`ifdef EX_OVERFLOW_EN
    ,
    output logic             overflow_out
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOR  = 4'd5,
        OP_SLT  = 4'd6,
        OP_SLTU = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_LUI  = 4'd11,
        OP_MUL  = 4'd12
    } alu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    state_e state_q;
    state_e state_d;

    logic             issue_alu;
    logic             start_mul;
    logic             mul_done;

    logic [WIDTH-1:0] op_b;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_result;

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_next;
    logic [CW-1:0]      count_q;

    // Shifts always shift the register operand; only the amount source follows alu_src.
    assign op_b  = alu_src ? sign_extend_in : data_b_in;
    assign shamt = alu_src ? sign_extend_in[10:6] : data_a_in[4:0];
    assign sum   = data_a_in + op_b;
    assign diff  = data_a_in - op_b;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        alu_result = '0;
        case (alu_op)
            OP_ADD:  alu_result = sum;
            OP_SUB:  alu_result = diff;
            OP_AND:  alu_result = data_a_in & op_b;
            OP_OR:   alu_result = data_a_in | op_b;
            OP_XOR:  alu_result = data_a_in ^ op_b;
            OP_NOR:  alu_result = ~(data_a_in | op_b);
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(data_a_in) < $signed(op_b))};
            OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (data_a_in < op_b)};
            OP_SLL:  alu_result = data_b_in << shamt;
            OP_SRL:  alu_result = data_b_in >> shamt;
            OP_SRA:  alu_result = $unsigned($signed(data_b_in) >>> shamt);
            OP_LUI:  alu_result = op_b << 16;
            default: alu_result = '0;
        endcase
    end

`ifdef EX_OVERFLOW_EN
    logic alu_overflow;

    always_comb begin
        alu_overflow = 1'b0;
        if (alu_op == OP_ADD) begin
            alu_overflow = (data_a_in[WIDTH-1] == op_b[WIDTH-1]) &&
                           (sum[WIDTH-1] != data_a_in[WIDTH-1]);
        end else if (alu_op == OP_SUB) begin
            alu_overflow = (data_a_in[WIDTH-1] != op_b[WIDTH-1]) &&
                           (diff[WIDTH-1] != data_a_in[WIDTH-1]);
        end
    end
`endif

    // One shift-add step; on the final iteration this value is the full product.
    assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        issue_alu = 1'b0;
        start_mul = 1'b0;
        mul_done  = 1'b0;
        stall_out = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    if (alu_op == OP_MUL) begin
                        start_mul = 1'b1;
                        state_d   = S_MUL;
                    end else begin
                        issue_alu = 1'b1;
                    end
                end
            end
            S_MUL: begin
                stall_out = 1'b1;
                if (count_q == LAST_ITER) begin
                    mul_done = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: multiplier working registers are reset too, so an aborted multiply leaves no residue.
            result_out <= '0;
            hi_out     <= '0;
            zero_out   <= 1'b0;
            valid_out  <= 1'b0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            count_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            valid_out <= issue_alu | mul_done;

            if (issue_alu) begin
                result_out <= alu_result;
                zero_out   <= (alu_result == '0);
            end

            if (start_mul) begin
                mcand_q  <= {{WIDTH{1'b0}}, data_a_in};
                mplier_q <= op_b;
                acc_q    <= '0;
                count_q  <= '0;
            end else if (state_q == S_MUL) begin
                acc_q    <= acc_next;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                count_q  <= count_q + 1'b1;
            end

            if (mul_done) begin
                result_out <= acc_next[WIDTH-1:0];
                hi_out     <= acc_next[2*WIDTH-1:WIDTH];
                zero_out   <= (acc_next[WIDTH-1:0] == '0);
            end
        end
    end

`ifdef EX_OVERFLOW_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_out <= 1'b0;
        end else if (issue_alu) begin
            overflow_out <= alu_overflow;
        end else if (mul_done) begin
            overflow_out <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized ops against an arithmetic reference model.
// Define EX_OVERFLOW_EN for both bench and RTL to exercise the overflow flag.
module tb_ex_stage;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [3:0]    alu_op;
    logic          alu_src;
    logic [W-1:0]  data_a_in;
    logic [W-1:0]  data_b_in;
    logic [W-1:0]  sign_extend_in;
    logic [W-1:0]  result_out;
    logic [W-1:0]  hi_out;
    logic          zero_out;
    logic          valid_out;
    logic          stall_out;
`ifdef EX_OVERFLOW_EN
    logic          overflow_out;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ex_stage #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .valid_in       (valid_in),
        .alu_op         (alu_op),
        .alu_src        (alu_src),
        .data_a_in      (data_a_in),
        .data_b_in      (data_b_in),
        .sign_extend_in (sign_extend_in),
        .result_out     (result_out),
        .hi_out         (hi_out),
        .zero_out       (zero_out),
        .valid_out      (valid_out),
        .stall_out      (stall_out)
`ifdef EX_OVERFLOW_EN
        ,
        .overflow_out   (overflow_out)
`endif
    );

    // Reference model: each op computed directly from its arithmetic definition.
    function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input logic [W-1:0] imm,
                                                input logic src);
        logic [W-1:0] ob;
        int unsigned  sh;
        ob = src ? imm : b;
        sh = src ? int'(imm[10:6]) : int'(a[4:0]);
        case (op)
            4'd0:    return a + ob;
            4'd1:    return a - ob;
            4'd2:    return a & ob;
            4'd3:    return a | ob;
            4'd4:    return a ^ ob;
            4'd5:    return ~(a | ob);
            4'd6:    return ($signed(a) < $signed(ob)) ? 32'd1 : 32'd0;
            4'd7:    return (a < ob) ? 32'd1 : 32'd0;
            4'd8:    return b << sh;
            4'd9:    return b >> sh;
            4'd10:   return $unsigned($signed(b) >>> sh);
            4'd11:   return ob * 32'd65536;
            default: return '0;
        endcase
    endfunction

    function automatic bit ref_overflow(input logic [3:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] ob);
        longint s;
        if (op == 4'd0)      s = longint'($signed(a)) + longint'($signed(ob));
        else if (op == 4'd1) s = longint'($signed(a)) - longint'($signed(ob));
        else                 return 1'b0;
        return (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
    endfunction

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] imm, input logic src);
        valid_in       = 1'b1;
        alu_op         = op;
        data_a_in      = a;
        data_b_in      = b;
        sign_extend_in = imm;
        alu_src        = src;
    endtask

    // Issues a multiply and waits (bounded) for completion, scrambling the inputs while stalled.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] imm,
                           input logic src, output int edges, output int stalls, output bit seen);
        edges  = 0;
        stalls = 0;
        seen   = 1'b0;
        @(negedge clock);
        drive(4'd12, a, b, imm, src);
        for (int i = 0; i < 3 * W && !seen; i++) begin
            @(negedge clock);
            edges++;
            if (valid_out) begin
                seen = 1'b1;
            end else begin
                if (stall_out) stalls++;
                drive(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
                      1'($urandom_range(0, 1)));
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({result_out, hi_out, zero_out, valid_out, stall_out} !== {(2*W+3){1'b0}}) begin
            failures++;
            $display("FAIL reset_state: result=%h hi=%h zero=%b valid=%b stall=%b required all 0",
                     result_out, hi_out, zero_out, valid_out, stall_out);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_add;
        @(negedge clock);
        drive(4'd0, 32'h9, 32'h4, 32'h0, 1'b0);
        @(negedge clock);
        valid_in = 1'b0;
        reset    = 1'b1;
        #1;
        checks++;
        if ({result_out, zero_out, valid_out, stall_out} !== {(W+3){1'b0}}) begin
            failures++;
            $display("FAIL idle_reset_pulse: result=%h zero=%b valid=%b stall=%b required 0",
                     result_out, zero_out, valid_out, stall_out);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        drive(4'd0, 32'h5, 32'h3, 32'h0, 1'b0);
        @(negedge clock);
        valid_in = 1'b0;
        checks++;
        if ({result_out, zero_out, valid_out} !== {32'h8, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL add_5_3: result=%h zero=%b valid=%b required 00000008/0/1",
                     result_out, zero_out, valid_out);
        end
        @(negedge clock);
        checks++;
        if ({result_out, valid_out} !== {32'h8, 1'b0}) begin
            failures++;
            $display("FAIL add_pulse_hold: result=%h valid=%b required 00000008/0",
                     result_out, valid_out);
        end
    endtask

    task automatic test_sub;
        @(negedge clock);
        drive(4'd1, 32'h10, 32'h0, 32'hFFFF_FFF0, 1'b1);
        @(negedge clock);
        checks++;
        if ({result_out, zero_out, valid_out} !== {32'h20, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL sub_imm: result=%h zero=%b valid=%b required 00000020/0/1",
                     result_out, zero_out, valid_out);
        end
        drive(4'd1, 32'h7, 32'h7, 32'h0, 1'b0);
        @(negedge clock);
        valid_in = 1'b0;
        checks++;
        if ({result_out, zero_out, valid_out} !== {32'h0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL sub_zero: result=%h zero=%b valid=%b required 00000000/1/1",
                     result_out, zero_out, valid_out);
        end
    endtask

    task automatic test_shift_cmp;
        logic [3:0]   ops [4] = '{4'd10, 4'd6, 4'd7, 4'd11};
        logic [W-1:0] as  [4] = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        logic [W-1:0] bs  [4] = '{32'h8000_0000, 32'h1, 32'h1, 32'h0};
        logic [W-1:0] ims [4] = '{32'h0000_0100, 32'h0, 32'h0, 32'h0000_1234};
        logic         srcs[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] exps[4] = '{32'hF800_0000, 32'h1, 32'h0, 32'h1234_0000};
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            drive(ops[i], as[i], bs[i], ims[i], srcs[i]);
            @(negedge clock);
            valid_in = 1'b0;
            checks++;
            if ({result_out, valid_out} !== {exps[i], 1'b1}) begin
                failures++;
                $display("FAIL shift_cmp_lui[%0d] op=%0d: result=%h valid=%b required %h/1",
                         i, ops[i], result_out, valid_out, exps[i]);
            end
        end
    endtask

    task automatic test_mul;
        int edges, stalls;
        bit seen;
        run_mul(32'hFFFF_FFFF, 32'h2, 32'h0, 1'b0, edges, stalls, seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL mul_timeout: no valid_out within %0d cycles", 3 * W);
        end
        checks++;
        if (edges != W + 1 || stalls != W) begin
            failures++;
            $display("FAIL mul_timing: valid after %0d edges, stall %0d cycles; required %0d and %0d",
                     edges, stalls, W + 1, W);
        end
        checks++;
        if ({result_out, hi_out, zero_out, stall_out} !== {32'hFFFF_FFFE, 32'h1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mul_result: lo=%h hi=%h zero=%b stall=%b required FFFFFFFE/00000001/0/0",
                     result_out, hi_out, zero_out, stall_out);
        end
        // Issue in the first idle cycle after completion.
        drive(4'd0, 32'h100, 32'h23, 32'h0, 1'b0);
        @(negedge clock);
        valid_in = 1'b0;
        checks++;
        if ({result_out, hi_out, valid_out} !== {32'h123, 32'h1, 1'b1}) begin
            failures++;
            $display("FAIL add_after_mul: result=%h hi=%h valid=%b required 00000123/00000001/1",
                     result_out, hi_out, valid_out);
        end
        @(negedge clock);
        checks++;
        if (valid_out !== 1'b0) begin
            failures++;
            $display("FAIL add_after_mul_pulse: valid=%b required 0", valid_out);
        end
    endtask

    task automatic test_reset_mid_mul;
        int edges, stalls, spurious;
        bit seen;
        @(negedge clock);
        drive(4'd12, 32'h1234_5678, 32'h9ABC_DEF1, 32'h0, 1'b0);
        @(negedge clock);
        valid_in = 1'b0;
        repeat (9) @(negedge clock);
        checks++;
        if (stall_out !== 1'b1) begin
            failures++;
            $display("FAIL mid_mul_stall: stall=%b required 1", stall_out);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({result_out, hi_out, zero_out, valid_out, stall_out} !== {(2*W+3){1'b0}}) begin
            failures++;
            $display("FAIL mid_mul_reset: result=%h hi=%h zero=%b valid=%b stall=%b required all 0",
                     result_out, hi_out, zero_out, valid_out, stall_out);
        end
        @(negedge clock);
        reset    = 1'b0;
        spurious = 0;
        for (int i = 0; i < W + 8; i++) begin
            @(negedge clock);
            if (valid_out || stall_out) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL mid_mul_abort: %0d cycles with valid/stall after reset required 0", spurious);
        end
        run_mul(32'h3, 32'h4, 32'h0, 1'b0, edges, stalls, seen);
        checks++;
        if (!seen || {result_out, hi_out, zero_out} !== {32'd12, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL mul_3x4: seen=%b lo=%h hi=%h zero=%b required 1/0000000c/00000000/0",
                     seen, result_out, hi_out, zero_out);
        end
    endtask

    task automatic test_random_mul;
        int edges, stalls;
        bit seen;
        logic [W-1:0] a, b, imm;
        logic         src;
        logic [2*W-1:0] prod;
        for (int i = 0; i < 6; i++) begin
            a   = (i == 0) ? 32'h0 : $urandom;
            b   = $urandom;
            imm = $urandom;
            src = 1'($urandom_range(0, 1));
            prod = 64'(a) * 64'(src ? imm : b);
            run_mul(a, b, imm, src, edges, stalls, seen);
            checks++;
            if (!seen || edges != W + 1 || {hi_out, result_out} !== prod ||
                zero_out !== (prod[W-1:0] == '0)) begin
                failures++;
                $display("FAIL rand_mul[%0d]: seen=%b edges=%0d hi:lo=%h:%h zero=%b required %h zero=%b",
                         i, seen, edges, hi_out, result_out, zero_out, prod, (prod[W-1:0] == '0));
            end
`ifdef EX_OVERFLOW_EN
            checks++;
            if (overflow_out !== 1'b0) begin
                failures++;
                $display("FAIL rand_mul_ovf[%0d]: overflow=%b required 0", i, overflow_out);
            end
`endif
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]   op;
        logic [W-1:0] a, b, imm, exp;
        logic         src;
        @(negedge clock);
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 14));
            if (op >= 4'd12) op = op + 4'd1;
            a   = $urandom;
            b   = (i % 7 == 0) ? a : $urandom;
            imm = $urandom;
            src = 1'($urandom_range(0, 1));
            exp = ref_result(op, a, b, imm, src);
            drive(op, a, b, imm, src);
            @(negedge clock);
            checks++;
            if ({result_out, zero_out, valid_out} !== {exp, (exp == '0), 1'b1}) begin
                failures++;
                $display("FAIL b2b[%0d] op=%0d a=%h b=%h imm=%h src=%b: result=%h zero=%b valid=%b required %h/%b/1",
                         i, op, a, b, imm, src, result_out, zero_out, valid_out, exp, (exp == '0));
            end
`ifdef EX_OVERFLOW_EN
            checks++;
            if (overflow_out !== ref_overflow(op, a, src ? imm : b)) begin
                failures++;
                $display("FAIL b2b_ovf[%0d] op=%0d: overflow=%b required %b",
                         i, op, overflow_out, ref_overflow(op, a, src ? imm : b));
            end
`endif
            if ($urandom_range(0, 3) == 0) begin
                valid_in = 1'b0;
                @(negedge clock);
                checks++;
                if ({result_out, valid_out} !== {exp, 1'b0}) begin
                    failures++;
                    $display("FAIL idle_hold[%0d]: result=%h valid=%b required %h/0",
                             i, result_out, valid_out, exp);
                end
            end
        end
        valid_in = 1'b0;
    endtask

`ifdef EX_OVERFLOW_EN
    task automatic test_overflow;
        logic [3:0]   ops [3] = '{4'd0, 4'd1, 4'd0};
        logic [W-1:0] as  [3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h1};
        logic [W-1:0] bs  [3] = '{32'h1, 32'h1, 32'h1};
        logic [W-1:0] exps[3] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
        logic         ovfs[3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            drive(ops[i], as[i], bs[i], 32'h0, 1'b0);
            @(negedge clock);
            valid_in = 1'b0;
            checks++;
            if ({result_out, overflow_out} !== {exps[i], ovfs[i]}) begin
                failures++;
                $display("FAIL overflow[%0d]: result=%h overflow=%b required %h/%b",
                         i, result_out, overflow_out, exps[i], ovfs[i]);
            end
        end
    endtask
`endif

    initial begin
        reset          = 1'b1;
        valid_in       = 1'b0;
        alu_op         = 4'd0;
        alu_src        = 1'b0;
        data_a_in      = '0;
        data_b_in      = '0;
        sign_extend_in = '0;
        test_reset();
        test_add();
        test_sub();
        test_shift_cmp();
        test_mul();
        test_reset_mid_mul();
        test_random_mul();
        test_back_to_back();
`ifdef EX_OVERFLOW_EN
        test_overflow();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
